// File: rtl/vec_magnitude_seq.sv
// Multi-cycle vector magnitude: out_root = isqrt(a^2 + b^2), shift-add squares then restoring sqrt.
// Optional ROUND_EN macro: round-to-nearest root; out_rem is always the floor remainder.
module vec_magnitude_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_root,
    output logic [WIDTH+1:0] out_rem,
    output logic             busy
);

    localparam int SW = 2 * WIDTH + 1;
    localparam int PW = 2 * WIDTH;
    localparam int RW = WIDTH + 1;
    localparam int MW = WIDTH + 2;
    localparam int TW = WIDTH + 4;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE,
        SQ,
        SQRT,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0]    cnt;
    logic [PW-1:0]    cand_a;
    logic [PW-1:0]    cand_b;
    logic [PW-1:0]    acc_a;
    logic [PW-1:0]    acc_b;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [SW:0]      rad;
    logic [RW-1:0]    root_q;
    logic [MW-1:0]    rem_q;

    logic [PW-1:0] acc_a_nx;
    logic [PW-1:0] acc_b_nx;
    logic [SW-1:0] sum_nx;
    logic          sq_last;
    logic          rt_last;
    logic [TW-1:0] rem_sh;
    logic [TW-1:0] trial;
    logic          ge;
    logic [RW-1:0] root_nx;
    logic [MW-1:0] rem_nx;
    logic [RW-1:0] root_out;

    always_comb begin
        acc_a_nx = acc_a + (mul_a[0] ? cand_a : '0);
        acc_b_nx = acc_b + (mul_b[0] ? cand_b : '0);
        sum_nx   = {1'b0, acc_a_nx} + {1'b0, acc_b_nx};
        sq_last  = (cnt == CW'(WIDTH - 1));
        rt_last  = (cnt == CW'(WIDTH));
    end

    // One restoring step: bring down two radicand bits, try (root<<2)|1.
    always_comb begin
        rem_sh  = {rem_q, rad[SW:SW-1]};
        trial   = {1'b0, root_q, 2'b01};
        ge      = (rem_sh >= trial);
        rem_nx  = ge ? MW'(rem_sh - trial) : MW'(rem_sh);
        root_nx = {root_q[RW-2:0], ge};
`ifdef ROUND_EN
        root_out = root_nx + RW'(rem_nx > MW'(root_nx));
`else
        root_out = root_nx;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = SQ;
            SQ:      if (sq_last) state_nx = SQRT;
            SQRT:    if (rt_last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == SQ) || (state == SQRT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            cand_a   <= '0;
            cand_b   <= '0;
            acc_a    <= '0;
            acc_b    <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            rad      <= '0;
            root_q   <= '0;
            rem_q    <= '0;
            out_root <= '0;
            out_rem  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cand_a <= {{WIDTH{1'b0}}, in_a};
                        cand_b <= {{WIDTH{1'b0}}, in_b};
                        mul_a  <= in_a;
                        mul_b  <= in_b;
                        acc_a  <= '0;
                        acc_b  <= '0;
                        cnt    <= '0;
                    end
                end
                SQ: begin
                    acc_a  <= acc_a_nx;
                    acc_b  <= acc_b_nx;
                    cand_a <= cand_a << 1;
                    cand_b <= cand_b << 1;
                    mul_a  <= mul_a >> 1;
                    mul_b  <= mul_b >> 1;
                    cnt    <= cnt + CW'(1);
                    if (sq_last) begin
                        rad    <= {1'b0, sum_nx};
                        root_q <= '0;
                        rem_q  <= '0;
                        cnt    <= '0;
                    end
                end
                SQRT: begin
                    rad    <= rad << 2;
                    root_q <= root_nx;
                    rem_q  <= rem_nx;
                    cnt    <= cnt + CW'(1);
                    if (rt_last) begin
                        out_root <= root_out;
                        out_rem  <= rem_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
